// File: rtl/kronos_types.sv
// Shared constants, state type and address-range helper for the Kronos instruction memory.
package kronos_types;

    localparam logic [31:0] IMEM_OOR_DATA  = 32'h0;
    // Fibonacci taps for x^8 + x^6 + x^5 + x^4 + 1 (maximal length)
    localparam logic [7:0]  IMEM_LFSR_TAPS = 8'hB8;

    typedef enum logic {READY, WAIT} imem_state_t;

    function automatic logic imem_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned depth);
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && ((off >> 2) < depth);
    endfunction

endpackage

// File: rtl/kronos_spsram.sv
// Generic synchronous single-port RAM: one read or one write per enabled cycle.
module kronos_spsram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          en,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= wdata;
            end else begin
                rdata <= r_mem[addr];
            end
        end
    end

endmodule

// File: rtl/kronos_imem.sv
// Kronos instruction-memory responder with programmable wait states and a shared load port.
// Optional random wait term enabled by defining KRONOS_IMEM_RANDWAIT_EN.
module kronos_imem
    import kronos_types::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic        instr_ack,
    output logic [31:0] instr_data,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  WAIT_FIX = 5'(WAIT_CYCLES);

    imem_state_t r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_heldAddr;
    logic        r_ack;
    logic        r_oor;
    logic [31:0] r_dataHold;

    logic [4:0]    w_total;
    logic          w_launch;
    logic          w_redirect;
    logic [31:0]   w_rdAddr;
    logic          w_rdInRange;
    logic          w_ldInRange;
    logic [AW-1:0] w_rdIdx;
    logic [AW-1:0] w_ldIdx;
    logic [AW-1:0] w_ramAddr;
    logic          w_ramEn;
    logic [31:0]   w_rdata;

`ifdef KRONOS_IMEM_RANDWAIT_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (!rstz) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & IMEM_LFSR_TAPS)};
        end
    end

    assign w_total = WAIT_FIX + {3'b000, r_lfsr[1:0]};
`else
    logic w_unusedSeed;
    assign w_unusedSeed = ^LFSR_SEED;
    assign w_total      = WAIT_FIX;
`endif

    assign w_redirect = (instr_addr[31:2] != r_heldAddr[31:2]);

    // A read never launches while the load port owns the SRAM.
    always_comb begin
        w_launch = 1'b0;
        w_rdAddr = instr_addr;
        if (r_state == READY) begin
            w_launch = instr_req && !load_en && (w_total == 5'd0);
        end else begin
            w_rdAddr = r_heldAddr;
            w_launch = instr_req && !load_en && !w_redirect && (r_cnt <= 5'd1);
        end
    end

    assign w_rdInRange = imem_in_range(w_rdAddr, BASE_ADDR, DEPTH);
    assign w_ldInRange = imem_in_range(load_addr, BASE_ADDR, DEPTH);
    assign w_rdIdx     = AW'((w_rdAddr - BASE_ADDR) >> 2);
    assign w_ldIdx     = AW'((load_addr - BASE_ADDR) >> 2);
    assign w_ramEn     = (load_en && w_ldInRange) || (w_launch && w_rdInRange);
    assign w_ramAddr   = load_en ? w_ldIdx : w_rdIdx;

    kronos_spsram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (32)
    ) u_sram (
        .clk   (clk),
        .addr  (w_ramAddr),
        .en    (w_ramEn),
        .we    (load_en),
        .wdata (load_data),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rstz) begin
            r_state    <= READY;
            r_cnt      <= 5'd0;
            r_heldAddr <= 32'h0;
        end else begin
            case (r_state)
                READY: begin
                    if (instr_req && (w_total != 5'd0)) begin
                        r_heldAddr <= instr_addr;
                        r_cnt      <= w_total;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!instr_req) begin
                        r_cnt   <= 5'd0;
                        r_state <= READY;
                    end else if (w_redirect) begin
                        r_heldAddr <= instr_addr;
                        r_cnt      <= w_total;
                    end else if (!load_en) begin
                        if (r_cnt <= 5'd1) begin
                            r_cnt   <= 5'd0;
                            r_state <= READY;
                        end else begin
                            r_cnt <= r_cnt - 5'd1;
                        end
                    end
                end
                default: r_state <= READY;
            endcase
        end
    end

    // The SRAM output is only trusted in the ack cycle; otherwise the last delivered word is replayed.
    always_ff @(posedge clk) begin
        if (!rstz) begin
            r_ack      <= 1'b0;
            r_oor      <= 1'b0;
            r_dataHold <= 32'h0;
        end else begin
            r_ack <= w_launch;
            r_oor <= !w_rdInRange;
            if (r_ack) begin
                r_dataHold <= instr_data;
            end
        end
    end

    assign instr_ack  = r_ack;
    assign instr_data = r_ack ? (r_oor ? IMEM_OOR_DATA : w_rdata) : r_dataHold;

endmodule

// File: tb/tb_kronos_imem.sv
// Scoreboard bench for kronos_imem: three instances (wait 0/2/3, different depth and base)
// driven one at a time by randomized transactions against a word-array reference model.
module tb_kronos_imem;

    typedef struct {
        int          dut;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        rstz  = 1'b0;
    logic [2:0]  req   = 3'b000;
    logic [2:0]  ldEn  = 3'b000;
    logic [2:0]  ack;
    logic [31:0] addr   [3];
    logic [31:0] ldAddr [3];
    logic [31:0] ldData [3];
    logic [31:0] data   [3];

    int          waitOf   [3] = '{0, 2, 3};
    int          depthOf  [3] = '{16, 1024, 64};
    int          loadedOf [3] = '{16, 64, 64};
    logic [31:0] baseOf   [3] = '{32'h0, 32'h0, 32'h100};

    logic [31:0] mdl [3][1024];
    logic [31:0] lastData [3];
    exp_t        sbQ [$];
    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;
    logic        rstSeen = 1'b0;
    logic        monOn   = 1'b0;

    always #5 clock = ~clock;

    kronos_imem #(.DEPTH(16), .BASE_ADDR(32'h0), .WAIT_CYCLES(0), .LFSR_SEED(8'hA5)) dut0 (
        .clk(clock), .rstz(rstz), .instr_addr(addr[0]), .instr_req(req[0]),
        .instr_ack(ack[0]), .instr_data(data[0]),
        .load_en(ldEn[0]), .load_addr(ldAddr[0]), .load_data(ldData[0]));

    kronos_imem #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(2), .LFSR_SEED(8'hA5)) dut1 (
        .clk(clock), .rstz(rstz), .instr_addr(addr[1]), .instr_req(req[1]),
        .instr_ack(ack[1]), .instr_data(data[1]),
        .load_en(ldEn[1]), .load_addr(ldAddr[1]), .load_data(ldData[1]));

    kronos_imem #(.DEPTH(64), .BASE_ADDR(32'h100), .WAIT_CYCLES(3), .LFSR_SEED(8'hA5)) dut2 (
        .clk(clock), .rstz(rstz), .instr_addr(addr[2]), .instr_req(req[2]),
        .instr_ack(ack[2]), .instr_data(data[2]),
        .load_en(ldEn[2]), .load_addr(ldAddr[2]), .load_data(ldData[2]));

    always @(posedge clock) begin
        cyc     <= cyc + 1;
        rstSeen <= !rstz;
    end

    task automatic checkOutput(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d at cycle %0d: got %h, expected %h", name, k, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every ack and otherwise checks that the data output holds.
    always @(negedge clock) begin
        exp_t e;
        if (monOn) begin
            if (rstSeen) begin
                for (int j = 0; j < 3; j++) lastData[j] = 32'h0;
            end
            for (int k = 0; k < 3; k++) begin
                if (rstSeen) begin
                    checkOutput("resetAck", k, {31'b0, ack[k]}, 32'h0);
                    checkOutput("resetData", k, data[k], 32'h0);
                end else if (ack[k]) begin
                    if (sbQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL spuriousAck dut%0d at cycle %0d: got ack, expected none", k, cyc);
                    end else begin
                        e = sbQ.pop_front();
                        checkOutput("ackDut", k, 32'(k), 32'(e.dut));
                        checkOutput("ackCycle", k, 32'(cyc), 32'(e.cyc));
                        checkOutput("ackData", k, data[k], e.data);
                        lastData[k] = e.data;
                    end
                end else begin
                    checkOutput("holdData", k, data[k], lastData[k]);
                end
            end
        end
    end

    function automatic logic mdlInRange(input int k, input logic [31:0] a);
        return (a >= baseOf[k]) && (((a - baseOf[k]) >> 2) < 32'(depthOf[k]));
    endfunction

    function automatic logic [31:0] mdlRead(input int k, input logic [31:0] a);
        if (mdlInRange(k, a)) return mdl[k][(a - baseOf[k]) >> 2];
        return 32'h0;
    endfunction

    function automatic logic [31:0] randAddr(input int k);
        logic [31:0] a;
        int          pick;
        pick = int'($urandom_range(0, 7));
        if (pick == 0)
            a = baseOf[k] + 32'(4 * depthOf[k]) + 32'(4 * $urandom_range(0, 31));
        else if (pick == 1 && baseOf[k] != 32'h0)
            a = 32'($urandom_range(0, 32'(baseOf[k] - 1)));
        else
            a = baseOf[k] + 32'(4 * $urandom_range(0, loadedOf[k] - 1));
        a[1:0] = 2'($urandom_range(0, 3));
        return a;
    endfunction

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int k, input logic rq, input logic [31:0] a,
                         input logic le, input logic [31:0] la, input logic [31:0] ld);
        req[k]    = rq;
        addr[k]   = a;
        ldEn[k]   = le;
        ldAddr[k] = la;
        ldData[k] = ld;
    endtask

    task automatic pushExp(input int k, input logic [31:0] a, input int when);
        exp_t e;
        e.dut  = k;
        e.data = mdlRead(k, a);
        e.cyc  = when;
        sbQ.push_back(e);
    endtask

    task automatic doLoad(input int k, input logic [31:0] a, input logic [31:0] d);
        drive(k, 1'b0, 32'h0, 1'b1, a, d);
        if (mdlInRange(k, a)) mdl[k][(a - baseOf[k]) >> 2] = d;
        nextCycle();
        drive(k, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic doRead(input int k, input logic [31:0] a);
        drive(k, 1'b1, a, 1'b0, 32'h0, 32'h0);
        pushExp(k, a, cyc + 1 + waitOf[k]);
        repeat (waitOf[k] + 1) nextCycle();
        req[k] = 1'b0;
    endtask

    task automatic doCollide(input int k, input logic [31:0] a, input logic [31:0] d);
        drive(k, 1'b1, a, 1'b1, a, d);
        if (mdlInRange(k, a)) mdl[k][(a - baseOf[k]) >> 2] = d;
        nextCycle();
        doRead(k, a);
    endtask

    task automatic doDrop(input int k, input logic [31:0] a);
        drive(k, 1'b1, a, 1'b0, 32'h0, 32'h0);
        repeat ($urandom_range(1, waitOf[k])) nextCycle();
        req[k] = 1'b0;
        nextCycle();
    endtask

    task automatic doRedirect(input int k, input logic [31:0] a1, input logic [31:0] a2, input int h);
        drive(k, 1'b1, a1, 1'b0, 32'h0, 32'h0);
        repeat (h) nextCycle();
        addr[k] = a2;
        pushExp(k, a2, cyc + 1 + waitOf[k]);
        repeat (waitOf[k] + 1) nextCycle();
        req[k] = 1'b0;
    endtask

    task automatic doLoadInWait(input int k, input logic [31:0] a, input logic [31:0] d);
        int issue;
        issue = cyc;
        drive(k, 1'b1, a, 1'b0, 32'h0, 32'h0);
        nextCycle();
        drive(k, 1'b1, a, 1'b1, a, d);
        if (mdlInRange(k, a)) mdl[k][(a - baseOf[k]) >> 2] = d;
        pushExp(k, a, issue + 2 + waitOf[k]);
        nextCycle();
        ldEn[k] = 1'b0;
        repeat (waitOf[k]) nextCycle();
        req[k] = 1'b0;
    endtask

    task automatic applyStimulus(input int k, input int n);
        logic [31:0] a1;
        logic [31:0] a2;
        int          r;
        for (int i = 0; i < n; i++) begin
            r  = int'($urandom_range(0, 9));
            a1 = randAddr(k);
            if (r < 5) begin
                doRead(k, a1);
            end else if (r == 5) begin
                doLoad(k, a1, $urandom());
            end else if (r == 6) begin
                req[k] = 1'b0;
                nextCycle();
            end else if (waitOf[k] == 0) begin
                doCollide(k, a1, $urandom());
            end else if (r == 7) begin
                doDrop(k, a1);
            end else if (r == 8) begin
                a2 = randAddr(k);
                while (a2[31:2] == a1[31:2]) a2 = randAddr(k);
                doRedirect(k, a1, a2, int'($urandom_range(1, waitOf[k])));
            end else begin
                doLoadInWait(k, a1, $urandom());
            end
        end
        req[k] = 1'b0;
        nextCycle();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            drive(k, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
            lastData[k] = 32'h0;
        end
        nextCycle();
        monOn = 1'b1;
        repeat (2) nextCycle();
        rstz = 1'b1;
        nextCycle();

        // Program images: a known prefix for the streaming case, random words elsewhere.
        doLoad(0, 32'h0, 32'h13);
        doLoad(0, 32'h4, 32'h93);
        doLoad(0, 32'h8, 32'h113);
        doLoad(0, 32'hC, 32'h193);
        for (int i = 4; i < loadedOf[0]; i++) doLoad(0, 32'(4 * i), $urandom());
        for (int k = 1; k < 3; k++)
            for (int i = 0; i < loadedOf[k]; i++) doLoad(k, baseOf[k] + 32'(4 * i), $urandom());

        doRead(0, 32'h0);
        doRead(0, 32'h4);
        doRead(0, 32'h8);
        doRead(0, 32'hC);
        doRead(0, 32'h40);
        doLoad(0, 32'h40, 32'hFFFF_FFFF);
        for (int i = 0; i < 16; i++) doRead(0, 32'(4 * i));
        doCollide(0, 32'h4, 32'hDEAD_BEEF);
        applyStimulus(0, 80);

        doRead(1, 32'h8);
        doRead(1, 32'hC);
        applyStimulus(1, 60);

        doRedirect(2, 32'h100, 32'h140, 1);
        applyStimulus(2, 60);

        // Reset while dut1 is counting wait states; the pending read must vanish.
        drive(1, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
        nextCycle();
        rstz   = 1'b0;
        req[1] = 1'b0;
        nextCycle();
        rstz = 1'b1;
        nextCycle();
        doRead(1, 32'h10);
        applyStimulus(1, 20);

        repeat (8) nextCycle();
        checkOutput("pendingAcks", 0, 32'(sbQ.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kronos_imem.md
# kronos_imem

Instruction-memory responder for the Kronos instruction bus: the memory end of the `instr_req`/`instr_addr` → `instr_ack`/`instr_data` protocol driven by the fetch stage. It is built around a synchronous single-port SRAM, returns data one cycle after a request at full throughput, and can insert programmable wait states to exercise the fetch stage's miss and stall paths. A load port writes program images into the array and shares the single SRAM port with fetch reads.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words.
- `BASE_ADDR`, 32'h0: byte address of word 0.
- `WAIT_CYCLES`, 0: extra cycles inserted before each ack, range 0..15.
- `LFSR_SEED`, 8'hA5: reset value of the random-wait LFSR. Non-zero. Used only with the macro.

Ports:
- `clk` in 1: clock.
- `rstz` in 1: reset, synchronous, active-low.
- `instr_addr` in 32: request byte address. Bits [1:0] are ignored.
- `instr_req` in 1: request valid.
- `instr_ack` out 1: `instr_data` valid for the granted request.
- `instr_data` out 32: read data, registered.
- `load_en` in 1: write strobe.
- `load_addr` in 32: write byte address. Bits [1:0] are ignored.
- `load_data` in 32: write data.

## Operation
- Word index is `(addr - BASE_ADDR) >> 2`.
  - In range when `addr >= BASE_ADDR` and `index < DEPTH`.
  - An out-of-range read completes normally with data `IMEM_OOR_DATA` (32'h0).
  - An out-of-range load is dropped.
- States:
  - READY: a request is sampled.
    - If total wait is 0 and `load_en`=0, launch the read.
    - If total wait > 0, capture `instr_addr` into `held_addr`, set `cnt`=total wait, go to WAIT.
  - WAIT, with `instr_req`=0: go to READY, no ack.
  - WAIT, with `instr_addr`≠`held_addr` (redirect): recapture the address, reload `cnt`=total wait, stay in WAIT. Stale data is never acked.
  - WAIT, with `load_en`=1: `cnt` frozen, no launch.
  - WAIT, otherwise: if `cnt`==1, launch the read of `held_addr` and go to READY; else decrement `cnt`.
- Launch:
  - The SRAM is read this cycle.
  - Next cycle: `instr_ack`=1, `instr_data`=mem[index].
  - In every other cycle `instr_ack`=0 and `instr_data` holds its last value.
- Load port:
  - `load_en` has priority over reads for the single port.
  - In a READY cycle with both `load_en` and `instr_req`, no read is launched, so `instr_ack`=0 next cycle. The requester re-presents the address.
  - A write and a read in the same cycle cannot occur, so there is no read-during-write hazard.
- Total wait = `WAIT_CYCLES`, plus a random term when the macro is enabled.

## Timing
- Reset values:
  - `instr_ack`=0
  - `instr_data`=32'h0
  - state READY
  - `cnt`=0
  - `held_addr`=0
  - LFSR=`LFSR_SEED`
  - Memory contents are not reset.
- Zero wait: request in cycle N → ack in N+1. Back-to-back requests get one ack per cycle. The address may change every cycle.
- Wait W: request in N, held stable → ack in N+1+W. The ack cycle is READY and accepts the next request.
- A redirect during WAIT restarts the count from the new address's first cycle.
- Reset asserted mid-WAIT: the next cycle is READY, ack=0, and the pending read is discarded.
- A load always completes in its cycle. Its data is visible to a read launched in the following cycle.

## Configuration
- `KRONOS_IMEM_RANDWAIT_EN` defined:
  - An 8-bit Fibonacci LFSR (taps per `IMEM_LFSR_TAPS`) advances every cycle.
  - At each capture in READY, `lfsr[1:0]` is added to `WAIT_CYCLES`.
  - When the sum is 0, the read launches immediately.
- `KRONOS_IMEM_RANDWAIT_EN` not defined:
  - No LFSR.
  - Latency is exactly 1+`WAIT_CYCLES`, deterministic.

## Structure
- Package `kronos_types` adds:
  - `IMEM_OOR_DATA`
  - `IMEM_LFSR_TAPS`
  - the `imem_state_t` enum {READY, WAIT}
- Sub-module `kronos_spsram`:
  - Generic synchronous single-port RAM: `clk`, `addr`, `en`, `we`, `wdata`, `rdata`.
  - One read or one write per cycle.
  - `kronos_imem` owns arbitration, the FSM, the wait counter and the LFSR.

## Test plan
- Zero-wait stream: load mem[0..3]=0x13,0x93,0x113,0x193. Request addresses 0,4,8,12 on consecutive cycles → acks on 4 consecutive cycles with data 0x13,0x93,0x113,0x193 in that order.
- `WAIT_CYCLES`=2: request 0x8 held → `instr_ack`=0 for 2 cycles, then ack with mem[2]. Next request is accepted in the ack cycle.
- Redirect: `WAIT_CYCLES`=3. Request 0x0, change to 0x40 after 1 wait cycle → only one ack, with mem[16], 4 cycles after 0x40 first appears.
- Load/read collision: `load_en` with 0x4/0xDEADBEEF while requesting 0x4 → no ack next cycle. The re-presented request acks with 0xDEADBEEF.
- Out of range: `DEPTH`=16, request 0x40 → ack with 32'h0. Load to 0x40 leaves mem[0..15] unchanged.
- Reset in WAIT: `rstz`=0 mid-count → `instr_ack`=0 and state READY. The first request after reset sees full latency.
